// File: rtl/mb8_pkg.sv
// Shared types for the mb8 dictionary-memory arbiter: default address width,
// memory command record and arbiter state encoding.
package mb8_pkg;
  localparam int AW = 17;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] ai;
    logic [7:0]    vi;
  } mb8_cmd_t;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;
endpackage

// File: rtl/mb8_arb_rr_pick.sv
// Rotating priority encoder: first asserted req at or after start, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int c;
    c      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = (int'(start) + k) % N;
      if (!any && req[c]) begin
        any       = 1'b1;
        idx       = IW'(c);
        onehot[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mb8_arb.sv
// Round-robin arbiter sharing the single-port dictionary memory between N
// masters, with optional bounded burst locking and tagged read return.
//
// Handshake: req[i] is a request for one byte access this cycle; gnt[i] in the
// same cycle means the access was issued (no separate ready). A granted read
// returns exactly one cycle later as rvalid[i] with data on vo.
module mb8_arb #(
  parameter int N        = 3,
  parameter int AW       = mb8_pkg::AW,
  parameter int MAX_LOCK = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         lock,
  input  logic [N-1:0]         we,
  input  logic [N*AW-1:0]      ai,
  input  logic [N*8-1:0]       vi,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         rvalid,
  output logic [7:0]           vo,
  output logic                 m_we,
  output logic [AW-1:0]        m_ai,
  output logic [7:0]           m_vi,
  input  logic [7:0]           m_vo,
  output mb8_pkg::arb_state_e  state
);
  import mb8_pkg::*;

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(MAX_LOCK + 1);

  arb_state_e    state_n;
  logic [IW-1:0] owner, owner_n, start, gnt_idx, pick_idx, rd_id;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [N-1:0]  pick_oh;
  logic          pick_any, granted, rd_pend;

  // Search begins just past the last owner, so the last owner is lowest priority.
  assign start = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .start  (start),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    gnt     = '0;
    gnt_idx = owner;
    granted = 1'b0;
    if (!rst) begin
      if (state == HOLD) begin
        if (req[owner]) begin
          gnt[owner] = 1'b1;
          granted    = 1'b1;
        end
      end else if (pick_any) begin
        gnt     = pick_oh;
        gnt_idx = pick_idx;
        granted = 1'b1;
      end
    end
  end

  always_comb begin
    m_we = 1'b0;
    m_ai = '0;
    m_vi = '0;
    if (granted) begin
      m_we = we[gnt_idx];
      m_ai = ai[int'(gnt_idx)*AW +: AW];
      m_vi = vi[int'(gnt_idx)*8 +: 8];
    end
  end

  // lcnt counts beats already issued in the burst; the beat that would make
  // it MAX_LOCK is the last one.
  always_comb begin
    state_n = state;
    owner_n = owner;
    lcnt_n  = lcnt;
    case (state)
      ARB: begin
        if (granted) begin
          owner_n = gnt_idx;
          if (lock[gnt_idx] && MAX_LOCK > 1) begin
            state_n = HOLD;
            lcnt_n  = LW'(1);
          end
        end
      end
      HOLD: begin
        if (!req[owner] || !lock[owner] || lcnt >= LW'(MAX_LOCK - 1)) begin
          state_n = ARB;
          lcnt_n  = '0;
        end else begin
          lcnt_n = lcnt + LW'(1);
        end
      end
      default: begin
        state_n = ARB;
        lcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      owner   <= IW'(N - 1);
      lcnt    <= '0;
      rd_pend <= 1'b0;
      rd_id   <= '0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      lcnt    <= lcnt_n;
      rd_pend <= granted && !m_we;
      rd_id   <= gnt_idx;
    end
  end

  always_comb begin
    rvalid = '0;
    if (rd_pend) rvalid[rd_id] = 1'b1;
  end

  assign vo = m_vo;
endmodule
